// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared definitions for the UART transmit frame controller:
//   FSM state encoding, line levels for the start/stop framing bits,
//   and the parity type codes carried on PAR_TYP.
//   No ports (package).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_fsm_parity_calc.sv
// parity_calc
//   Combinational parity generator for one UART word.
//   Ports:
//     data     in  DATA_WIDTH  word to protect
//     par_typ  in  1           PAR_EVEN / PAR_ODD
//     par_bit  out 1           bit that makes the total count of ones
//                              even (PAR_EVEN) or odd (PAR_ODD)
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm
//   UART transmit frame controller. Drives the load/enable of an external
//   LSB-first serializer and muxes start, serial data, parity and stop bits
//   onto TX_OUT. CLK is the bit clock: one frame bit per cycle.
//   Build option: define UART_TX_TWO_STOP_EN for two stop bits (default one).
//   Ports:
//     CLK         in   1           bit clock
//     RST         in   1           synchronous active-high reset
//     P_DATA      in   DATA_WIDTH  word to send, latched on accept
//     Data_Valid  in   1           send request
//     PAR_EN      in   1           append parity bit (latched on accept)
//     PAR_TYP     in   1           0 even / 1 odd (latched on accept)
//     ser_out     in   1           current serializer bit
//     ser_done    in   1           serializer last-bit indication
//     ser_load    out  1           comb: load P_DATA into serializer
//     ser_en      out  1           comb: serializer advances on this edge
//     TX_OUT      out  1           registered serial line, idle high
//     Busy        out  1           registered, frame on the line
//     sync_err    out  1           registered pulse: ser_done disagreed
//                                  with the internal bit count
//
// state  | meaning
// IDLE   | line idle high, waiting for Data_Valid
// START  | start bit on the line, bit0 clocked out of the serializer
// DATA   | data bit cnt on the line
// PARITY | parity bit on the line
// STOP   | stop bit(s) on the line, back-to-back accept in the last one
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_out,
  input  logic                  ser_done,
  output logic                  ser_load,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  sync_err
);

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DATA_WIDTH - 2);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit;
  logic                  stop_last;
  logic                  exp_done;

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  assign stop_last = (stop_idx == 1'(STOP_BITS - 1));

  // The serializer has been enabled DATA_WIDTH times (START plus cnt+1 DATA
  // cycles) exactly when cnt reaches DATA_WIDTH-2.
  assign exp_done = (state == DATA) && (cnt == CNT_DONE);

  // ser_load doubles as the frame-accept strobe inside the FSM.
  always_comb begin
    ser_load = 1'b0;
    ser_en   = 1'b0;
    if (!RST) begin
      case (state)
        IDLE:    ser_load = Data_Valid;
        START:   ser_en   = 1'b1;
        DATA:    ser_en   = (cnt != CNT_LAST);
        STOP:    ser_load = Data_Valid && stop_last;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      stop_idx  <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= STOP_BIT;
      Busy      <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= (ser_done != exp_done);
      if (ser_load) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        state     <= START;
        TX_OUT    <= START_BIT;
        Busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            TX_OUT <= STOP_BIT;
            Busy   <= 1'b0;
          end
          START: begin
            state  <= DATA;
            cnt    <= '0;
            TX_OUT <= ser_out;
          end
          DATA: begin
            if (cnt == CNT_LAST) begin
              cnt      <= '0;
              stop_idx <= 1'b0;
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= STOP;
                TX_OUT <= STOP_BIT;
              end
            end else begin
              cnt    <= cnt + 1'b1;
              TX_OUT <= ser_out;
            end
          end
          PARITY: begin
            state    <= STOP;
            stop_idx <= 1'b0;
            TX_OUT   <= STOP_BIT;
          end
          STOP: begin
            if (stop_last) begin
              state  <= IDLE;
              TX_OUT <= STOP_BIT;
              Busy   <= 1'b0;
            end else begin
              stop_idx <= stop_idx + 1'b1;
              TX_OUT   <= STOP_BIT;
            end
          end
          default: begin
            state  <= IDLE;
            TX_OUT <= STOP_BIT;
            Busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
module tb_uart_tx_fsm;

  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid, PAR_EN, PAR_TYP;
  logic          ser_out, ser_done, ser_load, ser_en;
  logic          TX_OUT, Busy, sync_err;

  always #5 CLK = ~CLK;

  uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_out    (ser_out),
    .ser_done   (ser_done),
    .ser_load   (ser_load),
    .ser_en     (ser_en),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .sync_err   (sync_err)
  );

  // External serializer: loads on ser_load, shifts right on ser_en, and
  // flags done on the enable numbered done_at (0-based; DW-1 is correct).
  logic [DW-1:0] sr;
  int            en_idx;
  int            done_at;

  always @(posedge CLK) begin
    if (RST) begin
      sr     <= '0;
      en_idx <= 0;
    end else if (ser_load) begin
      sr     <= P_DATA;
      en_idx <= 0;
    end else if (ser_en) begin
      sr     <= sr >> 1;
      en_idx <= en_idx + 1;
    end
  end
  assign ser_out  = sr[0];
  assign ser_done = ser_en && (en_idx == done_at);

  // Reference model: queue of bits still to appear on the line.
  bit   q[$];
  logic tx_m, busy_m, serr_m;
  int   pos;
  int   total, bad;
  logic [31:0] tx_hist;
  int   serr_cnt, busy_low;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    int ones;
    q.delete();
    q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) q.push_back(((ones % 2) == 1) ^ pt);
    for (int i = 0; i < NSTOP; i++) q.push_back(1'b1);
  endtask

  // One bit period: drive after the falling edge, check comb outputs,
  // step the model across the rising edge, check registered outputs.
  task automatic cycle(input logic rst_v, input logic dv, input logic [DW-1:0] d,
                       input logic pe, input logic pt);
    logic accept, exp_en, mism;
    RST = rst_v; Data_Valid = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
    #1;
    accept = !rst_v && dv && (q.size() == 0);
    exp_en = !rst_v && busy_m && (pos <= DW - 1);
    mism   = (ser_done != (busy_m && pos == DW - 1));
    chk("ser_load", 32'(ser_load), 32'(accept));
    chk("ser_en", 32'(ser_en), 32'(exp_en));
    @(posedge CLK);
    if (rst_v) begin
      q.delete(); tx_m = 1'b1; busy_m = 1'b0; serr_m = 1'b0; pos = 0;
    end else begin
      serr_m = mism;
      if (q.size() > 0) begin
        tx_m = q.pop_front(); pos++;
      end else if (accept) begin
        build_frame(d, pe, pt);
        tx_m = q.pop_front(); busy_m = 1'b1; pos = 0;
      end else begin
        tx_m = 1'b1; busy_m = 1'b0;
      end
    end
    #1;
    chk("tx_out", 32'(TX_OUT), 32'(tx_m));
    chk("busy", 32'(Busy), 32'(busy_m));
    chk("sync_err", 32'(sync_err), 32'(serr_m));
    tx_hist = {tx_hist[30:0], TX_OUT};
    if (sync_err) serr_cnt++;
    if (!Busy) busy_low++;
    @(negedge CLK);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, DW'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    logic [9:0] a5_exp;
    total = 0; bad = 0; done_at = DW - 1;
    q.delete(); tx_m = 1'b1; busy_m = 1'b0; serr_m = 1'b0; pos = 0;
    tx_hist = '0; serr_cnt = 0; busy_low = 0;
    RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    @(negedge CLK);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle_n(2);

    // A5, no parity
    cycle(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, DW'($urandom), 1'b1, 1'b1);
    a5_exp = 10'b0101001011;
    chk("a5_stream", 32'(tx_hist[9:0]), 32'(a5_exp));
    idle_n(NSTOP + 1);

    // 07 with even then odd parity
    cycle(1'b0, 1'b1, 8'h07, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    chk("par_even", 32'(tx_hist[0]), 32'd1);
    idle_n(NSTOP + 1);
    cycle(1'b0, 1'b1, 8'h07, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("par_odd", 32'(tx_hist[0]), 32'd0);
    idle_n(NSTOP + 1);

    // Back-to-back with Data_Valid held high
    busy_low = 0;
    for (int i = 0; i < 9 + NSTOP; i++) cycle(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 9 + NSTOP; i++) cycle(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    chk("b2b_busy_low", 32'(busy_low), 32'd0);
    idle_n(NSTOP + 11);

    // Serializer done one enable early: two mismatching cycles
    done_at = DW - 2;
    serr_cnt = 0;
    cycle(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 10 + NSTOP; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("early_done_pulses", 32'(serr_cnt), 32'd2);
    done_at = DW - 1;
    idle_n(2);

    // Mid-frame reset
    cycle(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    idle_n(4);
    cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("rst_tx", 32'(TX_OUT), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_n(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      done_at = ($urandom_range(0, 15) == 0) ? DW - 2 : DW - 1;
      cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0),
            DW'($urandom), 1'($urandom), 1'($urandom));
    end
    done_at = DW - 1;
    idle_n(NSTOP + 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

endmodule
